mem_stage: RTL and testbench

Memory-access stage of the five-stage MIPS pipeline; consumes the EX/MEM pipeline register outputs (instruction, PC, ALU result, rt data) and drives the data-memory request/acknowledge interface. It performs byte, halfword and word loads and stores, stalls the upstream pipeline while an access is outstanding, and holds the MEM/WB register feeding write-back.

---
 rtl/mem_pkg.sv | 28 ++
 rtl/mem_load_align.sv | 34 +++
 rtl/mem_stage.sv | 192 +++++++++++++++++++
 tb/tb_mem_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: opcodes, FSM states and load kinds.
package mem_pkg;

  localparam int BE_W = 4;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_e;

  typedef enum logic [2:0] {
    LD_B,
    LD_BU,
    LD_H,
    LD_HU,
    LD_W
  } load_kind_e;

endpackage

// File: rtl/mem_load_align.sv
// Picks the addressed byte/halfword out of a little-endian read word and
// sign- or zero-extends it for write-back.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  load_kind_e  kind_i,
  output logic [31:0] data_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    byteSel = 8'h00;
    case (addr_lo_i)
      2'd0: byteSel = rdata_i[7:0];
      2'd1: byteSel = rdata_i[15:8];
      2'd2: byteSel = rdata_i[23:16];
      2'd3: byteSel = rdata_i[31:24];
    endcase
    halfSel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o  = rdata_i;
    case (kind_i)
      LD_B:    data_o = {{24{byteSel[7]}}, byteSel};
      LD_BU:   data_o = {24'h000000, byteSel};
      LD_H:    data_o = {{16{halfSel[15]}}, halfSel};
      LD_HU:   data_o = {16'h0000, halfSel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: data-memory request/ack handshake, pipeline stall and MEM/WB register.
// Optional misalignment trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_m,
  input  logic [31:0]       ins_m,
  input  logic [31:0]       pc_m,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       rt_data,
  output logic              stall_m,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [BE_W-1:0]   dmem_be,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic [31:0]       ins_w,
  output logic [31:0]       pc_w,
  output logic [31:0]       wb_data,
  output logic              addr_err,
  output logic [31:0]       err_pc
);

  state_e            state_q, state_d;
  logic              isLoad, isStore, misaligned, fault, startAccess;
  load_kind_e        loadKind;
  logic [BE_W-1:0]   beDec;
  logic [31:0]       wdataDec, loadData, wbData_d;
  logic [ADDR_W-1:0] memAddr;

  logic              reqWe_q;
  logic [BE_W-1:0]   reqBe_q;
  logic [ADDR_W-1:0] reqAddr_q;
  logic [31:0]       reqWdata_q;
  logic              wbValid_q;
  logic [31:0]       insW_q, pcW_q, wbData_q;

  assign memAddr = alu_result[ADDR_W-1:0];

  always_comb begin
    isLoad   = 1'b0;
    isStore  = 1'b0;
    loadKind = LD_W;
    beDec    = 4'b0000;
    wdataDec = 32'h0;
    case (ins_m[31:26])
      OP_LB:  begin isLoad = 1'b1; loadKind = LD_B;  beDec = 4'b0001 << memAddr[1:0]; end
      OP_LBU: begin isLoad = 1'b1; loadKind = LD_BU; beDec = 4'b0001 << memAddr[1:0]; end
      OP_LH:  begin isLoad = 1'b1; loadKind = LD_H;  beDec = 4'b0011 << {memAddr[1], 1'b0}; end
      OP_LHU: begin isLoad = 1'b1; loadKind = LD_HU; beDec = 4'b0011 << {memAddr[1], 1'b0}; end
      OP_LW:  begin isLoad = 1'b1; loadKind = LD_W;  beDec = 4'b1111; end
      OP_SB: begin
        isStore  = 1'b1;
        beDec    = 4'b0001 << memAddr[1:0];
        wdataDec = {4{rt_data[7:0]}};
      end
      OP_SH: begin
        isStore  = 1'b1;
        beDec    = 4'b0011 << {memAddr[1], 1'b0};
        wdataDec = {2{rt_data[15:0]}};
      end
      OP_SW: begin
        isStore  = 1'b1;
        beDec    = 4'b1111;
        wdataDec = rt_data;
      end
      default: ;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    case (ins_m[31:26])
      OP_LW, OP_SW:         misaligned = (memAddr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: misaligned = memAddr[0];
      default:              misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  // A faulting access never leaves IDLE, so it costs no stall.
  assign fault       = valid_m && misaligned && (state_q == ST_IDLE);
  assign startAccess = valid_m && (isLoad || isStore) && !misaligned && (state_q == ST_IDLE);

  always_comb begin
    state_d = state_q;
    stall_m = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (startAccess) begin
          stall_m = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (dmem_ack) state_d = ST_IDLE;
        else          stall_m = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      reqWe_q    <= 1'b0;
      reqBe_q    <= '0;
      reqAddr_q  <= '0;
      reqWdata_q <= '0;
    end else if (startAccess) begin
      reqWe_q    <= isStore;
      reqBe_q    <= beDec;
      reqAddr_q  <= {memAddr[ADDR_W-1:2], 2'b00};
      reqWdata_q <= wdataDec;
    end else if ((state_q == ST_BUSY) && dmem_ack) begin
      reqWe_q    <= 1'b0;
      reqBe_q    <= '0;
      reqAddr_q  <= '0;
      reqWdata_q <= '0;
    end
  end

  assign dmem_req   = (state_q == ST_BUSY);
  assign dmem_we    = reqWe_q;
  assign dmem_be    = reqBe_q;
  assign dmem_addr  = reqAddr_q;
  assign dmem_wdata = reqWdata_q;

  mem_load_align u_load_align (
    .rdata_i   (dmem_rdata),
    .addr_lo_i (memAddr[1:0]),
    .kind_i    (loadKind),
    .data_o    (loadData)
  );

  assign wbData_d = isLoad ? loadData : (isStore ? 32'h0 : alu_result);

  // Stalled or faulting cycles push a bubble into write-back.
  always_ff @(posedge clk) begin
    if (!reset || stall_m || fault) begin
      wbValid_q <= 1'b0;
      insW_q    <= '0;
      pcW_q     <= '0;
      wbData_q  <= '0;
    end else begin
      wbValid_q <= valid_m;
      insW_q    <= ins_m;
      pcW_q     <= pc_m;
      wbData_q  <= wbData_d;
    end
  end

  assign wb_valid = wbValid_q;
  assign ins_w    = insW_q;
  assign pc_w     = pcW_q;
  assign wb_data  = wbData_q;

`ifdef MEM_ALIGN_CHECK_EN
  logic        addrErr_q;
  logic [31:0] errPc_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      addrErr_q <= 1'b0;
      errPc_q   <= '0;
    end else begin
      addrErr_q <= fault;
      if (fault) errPc_q <= pc_m;
    end
  end

  assign addr_err = addrErr_q;
  assign err_pc   = errPc_q;
`else
  assign addr_err = 1'b0;
  assign err_pc   = 32'h0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed vectors push expected MEM/WB entries,
// a monitor pops them on every wb_valid. Build with MEM_ALIGN_CHECK_EN to test the trap.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset, valid_m, stall_m, dmem_req, dmem_we, dmem_ack;
  logic [31:0] ins_m, pc_m, alu_result, rt_data, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, ins_w, pc_w, wb_data, err_pc;
  logic        wb_valid, addr_err;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] data;
  } wb_t;

  wb_t sbQueue[$];
  int  checks = 0, errors = 0, cycle = 0, wbSeen = 0, expWbCount = 0;
  int  firstReq = -1, lastReq = -1, lwLast = 0;

  mem_stage #(.ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_m    (valid_m),
    .ins_m      (ins_m),
    .pc_m       (pc_m),
    .alu_result (alu_result),
    .rt_data    (rt_data),
    .stall_m    (stall_m),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_be    (dmem_be),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .wb_valid   (wb_valid),
    .ins_w      (ins_w),
    .pc_w       (pc_w),
    .wb_data    (wb_data),
    .addr_err   (addr_err),
    .err_pc     (err_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: every live write-back must match the oldest expected entry.
  always @(negedge clk) begin : monitor
    wb_t expEntry;
    if (reset === 1'b1 && wb_valid === 1'b1) begin
      wbSeen++;
      if (sbQueue.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_wb: got ins 0x%08h pc 0x%08h, expected no write-back", ins_w, pc_w);
      end else begin
        expEntry = sbQueue.pop_front();
        checkOutput("wb_ins", ins_w, expEntry.ins);
        checkOutput("wb_pc", pc_w, expEntry.pc);
        checkOutput("wb_data", wb_data, expEntry.data);
      end
    end
  end

  // Presents one instruction, acts as data memory (ack after ackDelay busy cycles)
  // and holds the inputs until the stage stops stalling.
  task automatic applyStimulus(
    input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] alu,
    input logic [31:0] rt, input logic [31:0] rdata, input int ackDelay, input int expStall,
    input logic expWb, input logic [31:0] expData, input logic expReq, input logic expWe,
    input logic chkBe, input logic [3:0] expBe, input logic [31:0] expAddr, input logic [31:0] expWdata);
    int   stalls = 0, busy = 0, iter = 0;
    logic done = 1'b0, sawReq = 1'b0;
    if (expWb) begin
      sbQueue.push_back(wb_t'{ins, pc, expData});
      expWbCount++;
    end
    @(negedge clk);
    valid_m    = v;
    ins_m      = ins;
    pc_m       = pc;
    alu_result = alu;
    rt_data    = rt;
    firstReq   = -1;
    while (!done && iter < 20) begin
      if (iter > 0) begin
        @(negedge clk);
        checkOutput("bubble_valid", {31'b0, wb_valid}, 32'h0);
        checkOutput("bubble_data", wb_data, 32'h0);
      end
      if (dmem_req) begin
        if (!sawReq) begin
          sawReq   = 1'b1;
          firstReq = cycle;
          checkOutput("req_we", {31'b0, dmem_we}, {31'b0, expWe});
          checkOutput("req_addr", dmem_addr, expAddr);
          if (chkBe) checkOutput("req_be", {28'b0, dmem_be}, {28'b0, expBe});
          if (expWe) checkOutput("req_wdata", dmem_wdata, expWdata);
        end
        lastReq    = cycle;
        dmem_ack   = (busy == ackDelay);
        dmem_rdata = rdata;
        busy++;
      end else begin
        dmem_ack = 1'b0;
      end
      #1;
      if (stall_m) stalls++;
      else         done = 1'b1;
      @(posedge clk);
      iter++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL stall_timeout: got stall after %0d cycles, expected release", iter);
    end
    checkOutput("stall_cycles", stalls, expStall);
    checkOutput("req_seen", {31'b0, sawReq}, {31'b0, expReq});
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_m  = 1'b0;
      dmem_ack = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, expected end of test");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset      = 1'b0;
    valid_m    = 1'b1;
    ins_m      = 32'h8CA4_0000;
    pc_m       = 32'h100;
    alu_result = 32'h10;
    rt_data    = 32'h0;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h5555_AAAA;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req", {31'b0, dmem_req}, 32'h0);
    checkOutput("rst_we", {31'b0, dmem_we}, 32'h0);
    checkOutput("rst_be", {28'b0, dmem_be}, 32'h0);
    checkOutput("rst_addr", dmem_addr, 32'h0);
    checkOutput("rst_wdata", dmem_wdata, 32'h0);
    checkOutput("rst_wb_valid", {31'b0, wb_valid}, 32'h0);
    checkOutput("rst_ins_w", ins_w, 32'h0);
    checkOutput("rst_pc_w", pc_w, 32'h0);
    checkOutput("rst_wb_data", wb_data, 32'h0);
    checkOutput("rst_addr_err", {31'b0, addr_err}, 32'h0);
    checkOutput("rst_err_pc", err_pc, 32'h0);
    valid_m  = 1'b0;
    dmem_ack = 1'b0;
    reset    = 1'b1;
    idleCycles(1);

    // add: single cycle, result passes through
    applyStimulus(1, 32'h0085_1020, 32'h400, 32'h1234, 32'h0, 32'h0, 0, 0,
                  1, 32'h1234, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    // lb / lbu at 0x103, ack after 3 waiting cycles
    applyStimulus(1, 32'h80A2_0003, 32'h404, 32'h103, 32'h0, 32'h80FF_0000, 3, 4,
                  1, 32'hFFFF_FF80, 1, 0, 0, 4'h0, 32'h100, 32'h0);
    applyStimulus(1, 32'h90A2_0003, 32'h408, 32'h103, 32'h0, 32'h80FF_0000, 3, 4,
                  1, 32'h0000_0080, 1, 0, 0, 4'h0, 32'h100, 32'h0);
    // sh at 0x202: upper half lanes, replicated data
    applyStimulus(1, 32'hA4A3_0002, 32'h40C, 32'h202, 32'hABCD_1234, 32'h0, 0, 1,
                  1, 32'h0, 1, 1, 1, 4'b1100, 32'h200, 32'h1234_1234);
    idleCycles(1);

    // lw then sw back-to-back with immediate ack
    applyStimulus(1, 32'h8CA4_0000, 32'h410, 32'h500, 32'h0, 32'hDEAD_BEEF, 0, 1,
                  1, 32'hDEAD_BEEF, 1, 0, 1, 4'b1111, 32'h500, 32'h0);
    lwLast = lastReq;
    applyStimulus(1, 32'hACA4_0004, 32'h414, 32'h504, 32'hCAFE_F00D, 32'h0, 0, 1,
                  1, 32'h0, 1, 1, 1, 4'b1111, 32'h504, 32'hCAFE_F00D);
    checkOutput("b2b_gap", firstReq, lwLast + 2);

    // halfword sign/zero extension and byte store lane
    applyStimulus(1, 32'h84A5_0002, 32'h418, 32'h102, 32'h0, 32'h80FF_0000, 1, 2,
                  1, 32'hFFFF_80FF, 1, 0, 0, 4'h0, 32'h100, 32'h0);
    applyStimulus(1, 32'h94A5_0000, 32'h41C, 32'h100, 32'h0, 32'h1234_8001, 0, 1,
                  1, 32'h0000_8001, 1, 0, 0, 4'h0, 32'h100, 32'h0);
    applyStimulus(1, 32'hA0A6_0001, 32'h420, 32'h101, 32'h1122_3344, 32'h0, 0, 1,
                  1, 32'h0, 1, 1, 1, 4'b0010, 32'h100, 32'h4444_4444);

    // memory opcode without valid_m: nothing happens
    applyStimulus(0, 32'h8CA4_0000, 32'h424, 32'h600, 32'h0, 32'h0, 0, 0,
                  0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    idleCycles(1);

    // misaligned lw at 0x301
`ifdef MEM_ALIGN_CHECK_EN
    applyStimulus(1, 32'h8CA7_0001, 32'h440, 32'h301, 32'h0, 32'h0102_0304, 0, 0,
                  0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    valid_m = 1'b0;
    checkOutput("addr_err_pulse", {31'b0, addr_err}, 32'h1);
    checkOutput("err_pc", err_pc, 32'h440);
    checkOutput("fault_wb_valid", {31'b0, wb_valid}, 32'h0);
    @(negedge clk);
    checkOutput("addr_err_clear", {31'b0, addr_err}, 32'h0);
`else
    applyStimulus(1, 32'h8CA7_0001, 32'h440, 32'h301, 32'h0, 32'h0102_0304, 0, 1,
                  1, 32'h0102_0304, 1, 0, 1, 4'b1111, 32'h300, 32'h0);
    #1;
    checkOutput("no_addr_err", {31'b0, addr_err}, 32'h0);
`endif

    idleCycles(3);
    checkOutput("sb_empty", sbQueue.size(), 32'h0);
    checkOutput("wb_count", wbSeen, expWbCount);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
